// File: rtl/crc16_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc16_arb_pkg
// Brief    : Shared state encoding and defaults for the crc16 engine arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package crc16_arb_pkg;

  // Arbiter state encoding
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;
  localparam logic [1:0] c_ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = c_ST_IDLE,
    S_ISSUE = c_ST_ISSUE,
    S_WAIT  = c_ST_WAIT,
    S_RESP  = c_ST_RESP
  } state_t;

  // Cycles the arbiter waits for the engine before giving up on a job
  localparam int c_DEFAULT_TIMEOUT = 64;

endpackage : crc16_arb_pkg
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Brief    : Two-way round-robin pick. A lone requester always wins; on a tie
//            the port named by rr_ptr wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  output logic valid,
  output logic winner
);

  // Tie goes to rr_ptr; otherwise the only active port wins (port 0 if none)
  always_comb begin
    valid  = req0 | req1;
    winner = (req0 & req1) ? rr_ptr : req1;
  end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/crc16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : crc16_arbiter
// Brief    : Shares a single crc_16 engine between the SD read path (port 0)
//            and the SD write/CRC-append path (port 1). Round-robin grant,
//            start pulse, bounded wait for done, ack with result or error.
// Revision : 1.0 - initial release
// ============================================================================
module crc16_arbiter
  import crc16_arb_pkg::*;
#(
  parameter int TIMEOUT = c_DEFAULT_TIMEOUT,
  parameter int TW      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] data0,
  output logic        gnt0,
  output logic        ack0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        gnt1,
  output logic        ack1,
  output logic [15:0] result,
  output logic        err,
  output logic        busy,
  output logic [31:0] eng_data,
  output logic        eng_start,
  input  logic        eng_done,
  input  logic [15:0] eng_result
);

  // Last timer value tolerated in WAIT before the job is declared dead
  localparam logic [TW-1:0] c_TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          eng_start_q, eng_start_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [15:0]   result_q, result_d;
  logic [31:0]   eng_data_q, eng_data_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          pick_valid;
  logic          pick_winner;

  rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Next-state and registered-output decode for the job sequencer
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    eng_start_d = 1'b0;
    err_d       = err_q;
    result_d    = result_q;
    eng_data_d  = eng_data_q;
    timer_d     = timer_q;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          owner_d     = pick_winner;
          eng_data_d  = pick_winner ? data1 : data0;
          gnt0_d      = ~pick_winner;
          gnt1_d      = pick_winner;
          eng_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Any done seen here is stale from the previous job
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) begin
          result_d = eng_result;
          err_d    = 1'b0;
          ack0_d   = ~owner_q;
          ack1_d   = owner_q;
          state_d  = S_RESP;
        end else if (timer_q == c_TIMER_LAST) begin
          result_d = 16'h0000;
          err_d    = 1'b1;
          ack0_d   = ~owner_q;
          ack1_d   = owner_q;
          state_d  = S_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        rr_ptr_d = ~owner_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      eng_start_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= 16'h0000;
      eng_data_q  <= 32'h0000_0000;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      eng_start_q <= eng_start_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      eng_data_q  <= eng_data_d;
      timer_q     <= timer_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign eng_start = eng_start_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign eng_data  = eng_data_q;

endmodule : crc16_arbiter
`default_nettype wire

// File: tb/tb_crc16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc16_arbiter
// Brief    : Directed self-checking bench for crc16_arbiter with a simple
//            XOR-fold engine model of programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc16_arbiter;

  localparam int c_TB_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [31:0] data0, data1;
  logic        gnt0, gnt1, ack0, ack1;
  logic [15:0] result;
  logic        err, busy;
  logic [31:0] eng_data;
  logic        eng_start;
  logic        eng_done;
  logic [15:0] eng_result;

  always #5 clk = ~clk;

  crc16_arbiter #(
    .TIMEOUT (c_TB_TIMEOUT),
    .TW      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .data0      (data0),
    .gnt0       (gnt0),
    .ack0       (ack0),
    .req1       (req1),
    .data1      (data1),
    .gnt1       (gnt1),
    .ack1       (ack1),
    .result     (result),
    .err        (err),
    .busy       (busy),
    .eng_data   (eng_data),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .eng_result (eng_result)
  );

  // Engine model: XOR fold, done rises lat edges after the start edge and
  // stays high until the next start; never_done suppresses it entirely.
  int          lat        = 1;
  bit          never_done = 1'b0;
  logic        force_done = 1'b0;
  logic        mdl_done   = 1'b0;
  logic [15:0] mdl_res    = 16'h0000;
  int          mdl_cnt    = 0;

  always @(posedge clk) begin
    if (eng_start) begin
      mdl_done <= 1'b0;
      mdl_res  <= eng_data[31:16] ^ eng_data[15:0];
      mdl_cnt  <= never_done ? 0 : lat;
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) mdl_done <= 1'b1;
    end
  end

  assign eng_done   = mdl_done | force_done;
  assign eng_result = mdl_res;

  // Pulse counters and collision monitor, sampled just after each edge
  int n_gnt0 = 0, n_gnt1 = 0, n_ack0 = 0, n_ack1 = 0, n_clash = 0;
  always @(posedge clk) begin
    #1;
    if (gnt0) n_gnt0++;
    if (gnt1) n_gnt1++;
    if (ack0) n_ack0++;
    if (ack1) n_ack1++;
    if ((gnt0 && gnt1) || (ack0 && ack1) || ((gnt0 || gnt1) && (ack0 || ack1)))
      n_clash++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return gnt0;
      1:       return gnt1;
      2:       return ack0;
      3:       return ack1;
      4:       return gnt0 | gnt1;
      default: return ack0 | ack1;
    endcase
  endfunction

  // Advance negedge by negedge until the selected output is high
  task automatic wait_for(input string tag, input int sel, input int budget, output int n);
    bit hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      hit = sig(sel);
    end
    if (!hit) chk({tag, "_wait"}, 32'(hit), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    bit hit;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_pulses",   32'({gnt0, gnt1, ack0, ack1, eng_start, err}), 32'd0);
    chk("rst_result",   32'(result), 32'd0);
    chk("rst_eng_data", eng_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single request on port 0, latency 2
    lat = 2; data0 = 32'h1234_ABCD; req0 = 1'b1;
    wait_for("t1_gnt0", 0, 10, n);
    chk("t1_gnt_lat",  32'(n), 32'd1);
    chk("t1_start",    32'(eng_start), 32'd1);
    chk("t1_eng_data", eng_data, 32'h1234_ABCD);
    chk("t1_busy",     32'(busy), 32'd1);
    req0 = 1'b0;
    wait_for("t1_ack0", 2, 20, n);
    chk("t1_ack_lat", 32'(n), 32'd4);
    chk("t1_result",  32'(result), 32'h0000_B9F9);
    chk("t1_err",     32'(err), 32'd0);
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_no_port1",  32'(n_gnt1 + n_ack1), 32'd0);

    // Simultaneous requests straight after reset
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    lat = 1; data0 = 32'h0000_FFFF; data1 = 32'hFFFF_0001; req0 = 1'b1; req1 = 1'b1;
    wait_for("t2_gnt_a", 4, 10, n);
    chk("t2_first_gnt", 32'({gnt1, gnt0}), 32'b01);
    req0 = 1'b0; data0 = '0;
    wait_for("t2_ack_a", 5, 20, n);
    chk("t2_first_ack", 32'({ack1, ack0}), 32'b01);
    chk("t2_result0",   32'(result), 32'h0000_FFFF);
    wait_for("t2_gnt_b", 4, 10, n);
    chk("t2_second_gnt", 32'({gnt1, gnt0}), 32'b10);
    chk("t2_eng_data1",  eng_data, 32'hFFFF_0001);
    req1 = 1'b0;
    wait_for("t2_ack_b", 5, 20, n);
    chk("t2_second_ack", 32'({ack1, ack0}), 32'b10);
    chk("t2_result1",    32'(result), 32'h0000_FFFE);
    chk("t2_err",        32'(err), 32'd0);
    repeat (2) @(negedge clk);

    // Both ports continuously requesting: grants must alternate
    base = n_gnt0 + n_gnt1;
    lat = 1; data0 = 32'hA5A5_0F0F; data1 = 32'h1111_2222; req0 = 1'b1; req1 = 1'b1;
    wait_for("t3_gnt_first", 4, 10, n);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("t3_gnt_port_%0d", j), 32'({gnt1, gnt0}), (j % 2) ? 32'b10 : 32'b01);
      wait_for($sformatf("t3_ack_%0d", j), 5, 20, n);
      chk($sformatf("t3_ack_port_%0d", j), 32'({ack1, ack0}), (j % 2) ? 32'b10 : 32'b01);
      chk($sformatf("t3_result_%0d", j), 32'(result), (j % 2) ? 32'h0000_3333 : 32'h0000_AAAA);
      if (j == 5) begin
        req0 = 1'b0; req1 = 1'b0;
      end else begin
        @(negedge clk);
        chk($sformatf("t3_idle_gap_%0d", j), 32'(busy), 32'd0);
        @(negedge clk);
        chk($sformatf("t3_busy_again_%0d", j), 32'(busy), 32'd1);
      end
    end
    repeat (3) @(negedge clk);
    chk("t3_gnt_count", 32'(n_gnt0 + n_gnt1 - base), 32'd6);

    // Timeout: engine never answers
    never_done = 1'b1; data0 = 32'hDEAD_BEEF; req0 = 1'b1;
    wait_for("t4_gnt0", 0, 10, n);
    req0 = 1'b0;
    wait_for("t4_ack0", 2, 30, n);
    chk("t4_ack_lat", 32'(n), 32'(c_TB_TIMEOUT + 1));
    chk("t4_err",     32'(err), 32'd1);
    chk("t4_result",  32'(result), 32'd0);
    base = n_ack0 + n_ack1;
    repeat (2) @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_late_done_acks", 32'(n_ack0 + n_ack1 - base), 32'd0);
    chk("t4_late_done_busy", 32'(busy), 32'd0);
    never_done = 1'b0; lat = 2; data0 = 32'hCAFE_0000; req0 = 1'b1;
    wait_for("t4b_gnt0", 0, 10, n);
    req0 = 1'b0;
    wait_for("t4b_ack0", 2, 20, n);
    chk("t4b_result", 32'(result), 32'h0000_CAFE);
    chk("t4b_err",    32'(err), 32'd0);

    // Reset in the middle of WAIT
    never_done = 1'b1; data0 = 32'h5555_AAAA; req0 = 1'b1;
    wait_for("t5_gnt0", 0, 10, n);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy",     32'(busy), 32'd0);
    chk("t5_pulses",   32'({gnt0, gnt1, ack0, ack1, eng_start, err}), 32'd0);
    chk("t5_result",   32'(result), 32'd0);
    chk("t5_eng_data", eng_data, 32'd0);
    base = n_ack0 + n_ack1;
    repeat (12) @(negedge clk);
    chk("t5_no_ack", 32'(n_ack0 + n_ack1 - base), 32'd0);
    never_done = 1'b0; lat = 1; data1 = 32'h1357_2468; req1 = 1'b1;
    wait_for("t5_gnt", 4, 10, n);
    chk("t5_gnt_port", 32'({gnt1, gnt0}), 32'b10);
    req1 = 1'b0;
    wait_for("t5_ack", 5, 20, n);
    chk("t5_ack_port", 32'({ack1, ack0}), 32'b10);
    chk("t5_result1",  32'(result), 32'h0000_373F);
    chk("t5_err",      32'(err), 32'd0);

    // Early request drop: job still completes, operand held
    lat = 3; data1 = 32'h4321_8765; req1 = 1'b1;
    wait_for("t6_gnt1", 1, 10, n);
    @(negedge clk);
    req1 = 1'b0; data1 = 32'hFFFF_FFFF;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (ack1) begin
        hit = 1'b1;
      end else begin
        chk("t6_eng_data_hold", eng_data, 32'h4321_8765);
        @(negedge clk);
      end
    end
    chk("t6_ack_seen", 32'(hit), 32'd1);
    chk("t6_result",   32'(result), 32'h0000_C444);
    chk("t6_err",      32'(err), 32'd0);
    repeat (3) @(negedge clk);

    chk("no_clash", 32'(n_clash), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_crc16_arbiter
`default_nettype wire
